// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters with registered coordinate, blank and sync decode.
// Optional macro SYNC_ALIGN_EN delays hs/vs by two clocks to line up with renderer RGB.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Free-running: no handshake, every clock advances one pixel.
    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic [9:0] r_draw_x;
    logic [9:0] r_draw_y;
    logic       r_blank;
    logic       r_hs;
    logic       r_vs;
    logic       r_frame_start;
    logic [7:0] r_frame_count;

    logic w_h_last;
    logic w_v_last;
    logic w_visible;
    logic w_hsync_on;
    logic w_vsync_on;

    assign w_h_last   = (r_hc == H_LAST);
    assign w_v_last   = (r_vc == V_LAST);
    assign w_visible  = (r_hc < H_VIS) && (r_vc < V_VIS);
    assign w_hsync_on = (r_hc >= HS_FIRST) && (r_hc <= HS_LAST);
    assign w_vsync_on = (r_vc >= VS_FIRST) && (r_vc <= VS_LAST);

    // Outputs load the decode of the pre-edge counters so they all describe one pixel.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc          <= 10'd0;
            r_vc          <= 10'd0;
            r_draw_x      <= 10'd0;
            r_draw_y      <= 10'd0;
            r_blank       <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_hc <= w_h_last ? 10'd0 : r_hc + 10'd1;
            if (w_h_last) begin
                r_vc <= w_v_last ? 10'd0 : r_vc + 10'd1;
            end
            r_draw_x      <= r_hc;
            r_draw_y      <= r_vc;
            r_blank       <= w_visible;
            r_hs          <= ~w_hsync_on;
            r_vs          <= ~w_vsync_on;
            r_frame_start <= (r_hc == 10'd0) && (r_vc == 10'd0);
            if (w_h_last && w_v_last) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign DrawX       = r_draw_x;
    assign DrawY       = r_draw_y;
    assign blank       = r_blank;
    assign frame_start = r_frame_start;
    assign frame_count = r_frame_count;

`ifdef SYNC_ALIGN_EN
    logic r_hs_d1;
    logic r_hs_d2;
    logic r_vs_d1;
    logic r_vs_d2;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hs_d1 <= 1'b1;
            r_hs_d2 <= 1'b1;
            r_vs_d1 <= 1'b1;
            r_vs_d2 <= 1'b1;
        end else begin
            r_hs_d1 <= r_hs;
            r_hs_d2 <= r_hs_d1;
            r_vs_d1 <= r_vs;
            r_vs_d2 <= r_vs_d1;
        end
    end

    assign hs = r_hs_d2;
    assign vs = r_vs_d2;
`else
    assign hs = r_hs;
    assign vs = r_vs;
`endif

endmodule
